lsu_queue: RTL and testbench
============================

Name: lsu_queue

Overview:
- Parametrised load/store unit; next generation of the combinational MEM stage.
- Sits between EX and WB and talks to the DCache over an SRAM-like addr_ok/data_ok interface.
- Adds: valid/ready handshake, up to MAX_OUT in-order outstanding accesses, alignment exceptions, flush with stale-response discard, 32/64-bit data path.
- Every accepted op (load, store, non-memory) retires exactly once, in program order.

Parameters:
- DATA_W, 32, data path width; 32 or 64. NB = DATA_W/8, OFS_W = log2(NB).
- ADDR_W, 32, address width.
- MAX_OUT, 2, queue depth = max in-flight ops; power of two, 1..8.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill all queued/in-flight ops
- in_valid  in  1  EX op valid
- in_ready  out  1  op accepted this cycle
- in_ls  in  2  00 none, 01 load, 10 store, 11 treated as none
- in_size  in  2  0 B, 1 H, 2 W, 3 D (legal only if DATA_W=64)
- in_sign  in  1  sign-extend load
- in_addr  in  ADDR_W  effective address
- in_data  in  DATA_W  store data, or pass-through result for non-memory ops
- d_req  out  1  cache request
- d_wr  out  1  1 = store
- d_size  out  3  {0,in_size}
- d_addr  out  ADDR_W  in_addr unmodified
- d_wstrb  out  NB  byte enables; zero for loads
- d_wdata  out  DATA_W  lane-aligned store data
- d_addr_ok  in  1  request accepted
- d_data_ok  in  1  response (loads and stores), in request order
- d_rdata  in  DATA_W  load data
- out_valid  out  1  head result valid
- out_ready  in  1  WB accepts
- out_data  out  DATA_W  result
- out_exc  out  2  00 none, 01 load address error, 10 store address error
- out_badvaddr  out  ADDR_W  faulting address

Behaviour:
- Reset: queue empty, discard_cnt=0. All outputs 0, except in_ready (combinational, 1 when idle and in_valid with a non-memory op).
- Misalign: in_addr mod (1<<in_size) != 0, or in_size=3 with DATA_W=32.
- Lane math:
  - ofs = in_addr[OFS_W-1:0]
  - d_wstrb = ((1<<(1<<in_size))-1) << ofs
  - d_wdata = in_data << (8*ofs)
- Acceptance (combinational, requires !flush and queue not full):
  - Non-memory op, or misaligned memory op: in_ready=1 and enqueued as done. Data = in_data or 0; exc/badvaddr set for misaligned.
  - Aligned memory op: d_req=1. in_ready=d_addr_ok. Enqueued as pending with ofs, size, sign, wr.
  - d_req never asserts for misaligned ops, when full, or during flush.
- Response: d_data_ok with discard_cnt>0 decrements discard_cnt and is otherwise ignored.
  - Otherwise it completes the oldest pending entry:
    - load data = extend(d_rdata >> 8*ofs, size, sign)
    - store data = 0
  - d_data_ok with no pending entry is ignored.
- Retire: out_* driven from the head entry when it is done. Pop on out_valid && out_ready.
  - No same-cycle bypass: a load accepted at cycle T with data_ok at T+k has out_valid at T+k+1.
  - A non-memory op accepted at T has out_valid at T+1 if it is the head.
- Full queue: accept and pop in the same cycle is not allowed; accept waits one cycle. Completion and pop in the same cycle are allowed on different entries.
- Flush: queue cleared at the clock edge. discard_cnt += (issued memory entries not yet responded), minus 1 if d_data_ok in the same cycle. out_valid=0 the next cycle.
  - New requests may issue while discard_cnt>0; in-order responses keep them distinct.
- Reset mid-operation: all state cleared immediately. No response tracking survives.

Test Plan:
- DATA_W=32, LB sign=1 addr 0x1003, rdata 0x80AA_BBCC, data_ok 2 cycles after addr_ok -> d_wstrb=0, out_data=0xFFFF_FF80 exactly 1 cycle after data_ok.
- DATA_W=64, SH addr 0x...6, in_data 0x1234 -> d_wstrb=0xC0, d_wdata=0x1234<<48; out_data=0 after data_ok.
- LW addr 0x1002 -> no d_req, out_valid next cycle with out_exc=01, out_badvaddr=0x1002. SW misaligned -> out_exc=10.
- MAX_OUT=2: two loads back-to-back, third op stalled (in_ready=0) until the first retires. Responses 0x11, 0x22 retire in order. out_ready held low 3 cycles -> no loss.
- Two loads in flight, flush -> queue empty, discard_cnt=2. Next two data_ok ignored. A new load issued during discard returns its own third response.
- resetn low while a load is pending -> outputs 0 immediately. After release, first op behaves as from idle.

Source files
------------

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store unit sitting between EX and WB.
// Accepts one op per cycle over a valid/ready handshake and keeps up to MAX_OUT ops in flight.
// Talks to the DCache over an addr_ok/data_ok SRAM-like interface.
// Misaligned accesses retire with an exception and never reach the cache.
// A flush drops every queued op. Responses still owed by the cache are counted and discarded.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   flush                 kill all queued / in-flight ops
//   in_*                  EX-side op (valid/ready, ls kind, size, sign, addr, data)
//   d_req .. d_wdata      cache request (combinational from the EX op)
//   d_addr_ok, d_data_ok  cache handshake; d_rdata carries load data
//   out_*                 WB-side result of the head entry (valid/ready, data, exc, badvaddr)
module lsu_queue #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_ls,
  input  logic [1:0]            in_size,
  input  logic                  in_sign,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  d_req,
  output logic                  d_wr,
  output logic [2:0]            d_size,
  output logic [ADDR_W-1:0]     d_addr,
  output logic [DATA_W/8-1:0]   d_wstrb,
  output logic [DATA_W-1:0]     d_wdata,
  input  logic                  d_addr_ok,
  input  logic                  d_data_ok,
  input  logic [DATA_W-1:0]     d_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_exc,
  output logic [ADDR_W-1:0]     out_badvaddr
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(NB);
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [DATA_W-1:0] ONES = '1;

  // Per-entry state. An entry that is valid but not done is an issued memory op awaiting data_ok.
  logic [MAX_OUT-1:0] vld_q, done_q, wr_q, sign_q;
  logic [1:0]         size_q [MAX_OUT];
  logic [OFS_W-1:0]   ofs_q  [MAX_OUT];
  logic [DATA_W-1:0]  data_q [MAX_OUT];
  logic [1:0]         exc_q  [MAX_OUT];
  logic [ADDR_W-1:0]  bad_q  [MAX_OUT];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       disc_q, disc_d;

  logic             is_load, is_store, is_mem, misalign, full, can_acc, issue, push, pop;
  logic [OFS_W-1:0] ofs;
  logic [15:0]      bmask, strb_full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request decode and lane steering.
  always_comb begin
    is_load  = (in_ls == 2'b01);
    is_store = (in_ls == 2'b10);
    is_mem   = is_load | is_store;
    ofs      = in_addr[OFS_W-1:0];
    unique case (in_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = in_addr[0];
      2'd2:    misalign = |in_addr[1:0];
      default: misalign = (DATA_W == 32) || (|in_addr[2:0]);
    endcase
    full      = (cnt_q == CNT_W'(MAX_OUT));
    can_acc   = in_valid && !flush && !full;
    issue     = can_acc && is_mem && !misalign;
    in_ready  = can_acc && (!(is_mem && !misalign) || d_addr_ok);
    push      = in_ready;
    bmask     = (16'd1 << (5'd1 << in_size)) - 16'd1;
    strb_full = bmask << ofs;
    d_req     = issue;
    d_wr      = is_store;
    d_size    = {1'b0, in_size};
    d_addr    = in_addr;
    d_wstrb   = is_store ? strb_full[NB-1:0] : '0;
    d_wdata   = in_data << {ofs, 3'b000};
  end

  // Oldest pending entry, plus how many are pending (needed when a flush orphans them).
  logic             found;
  logic [PTR_W-1:0] pidx, idx;
  logic [7:0]       pend_cnt;

  always_comb begin
    found    = 1'b0;
    pidx     = '0;
    idx      = '0;
    pend_cnt = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      idx = head_q + PTR_W'(i);  // wraps naturally: MAX_OUT is a power of two
      if (vld_q[idx] && !done_q[idx]) begin
        pend_cnt = pend_cnt + 8'd1;
        if (!found) begin
          found = 1'b1;
          pidx  = idx;
        end
      end
    end
  end

  // Response handling: stale responses are eaten first, then the oldest pending entry completes.
  logic              consume, complete, msb;
  logic [DATA_W-1:0] rsh, lmask, resp_data;

  always_comb begin
    consume  = d_data_ok && ((disc_q != 8'd0) || found);
    complete = d_data_ok && (disc_q == 8'd0) && found;
    rsh      = d_rdata >> {ofs_q[pidx], 3'b000};
    unique case (size_q[pidx])
      2'd0:    begin lmask = ONES >> (DATA_W - 8);  msb = rsh[7];        end
      2'd1:    begin lmask = ONES >> (DATA_W - 16); msb = rsh[15];       end
      2'd2:    begin lmask = ONES >> (DATA_W - 32); msb = rsh[31];       end
      default: begin lmask = ONES;                  msb = rsh[DATA_W-1]; end
    endcase
    if (wr_q[pidx])                resp_data = '0;
    else if (sign_q[pidx] && msb)  resp_data = rsh | ~lmask;
    else                           resp_data = rsh & lmask;

    disc_d = disc_q;
    if (flush)                                  disc_d = disc_q + pend_cnt - {7'd0, consume};
    else if (d_data_ok && (disc_q != 8'd0))     disc_d = disc_q - 8'd1;
  end

  // Retire from the head.
  always_comb begin
    out_valid    = vld_q[head_q] && done_q[head_q];
    pop          = out_valid && out_ready;
    out_data     = out_valid ? data_q[head_q] : '0;
    out_exc      = out_valid ? exc_q[head_q]  : 2'b00;
    out_badvaddr = out_valid ? bad_q[head_q]  : '0;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Push never targets a live entry (blocked when full), and complete/pop never share an entry
  // (complete needs !done, pop needs done), so the writes below never collide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q  <= '0;
      done_q <= '0;
      wr_q   <= '0;
      sign_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      disc_q <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        size_q[i] <= '0;
        ofs_q[i]  <= '0;
        data_q[i] <= '0;
        exc_q[i]  <= '0;
        bad_q[i]  <= '0;
      end
    end else if (flush) begin
      vld_q  <= '0;
      done_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      disc_q <= disc_d;
    end else begin
      if (complete) begin
        done_q[pidx] <= 1'b1;
        data_q[pidx] <= resp_data;
      end
      if (push) begin
        vld_q[tail_q]  <= 1'b1;
        done_q[tail_q] <= !issue;
        wr_q[tail_q]   <= is_store;
        sign_q[tail_q] <= in_sign;
        size_q[tail_q] <= in_size;
        ofs_q[tail_q]  <= ofs;
        data_q[tail_q] <= is_mem ? '0 : in_data;
        exc_q[tail_q]  <= (is_mem && misalign) ? (is_load ? 2'b01 : 2'b10) : 2'b00;
        bad_q[tail_q]  <= (is_mem && misalign) ? in_addr : '0;
        tail_q         <= ptr_inc(tail_q);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= ptr_inc(head_q);
      end
      cnt_q  <= cnt_d;
      disc_q <= disc_d;
    end
  end

endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed bench for lsu_queue with a 32-bit instance (a_*) and a 64-bit instance
// (b_*). Expected retirements are queued when each op is issued. A monitor per instance pops
// and compares them whenever the DUT retires.
module tb_lsu_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, flush;

  logic        a_in_valid, a_in_ready, a_in_sign, a_d_req, a_d_wr, a_d_addr_ok, a_d_data_ok;
  logic        a_out_valid, a_out_ready;
  logic [1:0]  a_in_ls, a_in_size, a_out_exc;
  logic [2:0]  a_d_size;
  logic [3:0]  a_d_wstrb;
  logic [31:0] a_in_addr, a_in_data, a_d_addr, a_d_wdata, a_d_rdata, a_out_data, a_out_badvaddr;

  logic        b_in_valid, b_in_ready, b_in_sign, b_d_req, b_d_wr, b_d_addr_ok, b_d_data_ok;
  logic        b_out_valid, b_out_ready;
  logic [1:0]  b_in_ls, b_in_size, b_out_exc;
  logic [2:0]  b_d_size;
  logic [7:0]  b_d_wstrb;
  logic [31:0] b_in_addr, b_d_addr, b_out_badvaddr;
  logic [63:0] b_in_data, b_d_wdata, b_d_rdata, b_out_data;

  lsu_queue #(.DATA_W(32), .ADDR_W(32), .MAX_OUT(2)) u_a (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ls(a_in_ls), .in_size(a_in_size),
    .in_sign(a_in_sign), .in_addr(a_in_addr), .in_data(a_in_data),
    .d_req(a_d_req), .d_wr(a_d_wr), .d_size(a_d_size), .d_addr(a_d_addr),
    .d_wstrb(a_d_wstrb), .d_wdata(a_d_wdata), .d_addr_ok(a_d_addr_ok),
    .d_data_ok(a_d_data_ok), .d_rdata(a_d_rdata),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_exc(a_out_exc), .out_badvaddr(a_out_badvaddr)
  );

  lsu_queue #(.DATA_W(64), .ADDR_W(32), .MAX_OUT(2)) u_b (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ls(b_in_ls), .in_size(b_in_size),
    .in_sign(b_in_sign), .in_addr(b_in_addr), .in_data(b_in_data),
    .d_req(b_d_req), .d_wr(b_d_wr), .d_size(b_d_size), .d_addr(b_d_addr),
    .d_wstrb(b_d_wstrb), .d_wdata(b_d_wdata), .d_addr_ok(b_d_addr_ok),
    .d_data_ok(b_d_data_ok), .d_rdata(b_d_rdata),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_exc(b_out_exc), .out_badvaddr(b_out_badvaddr)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  exc;
    logic [31:0] bad;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitors: compare every retirement against the oldest expectation.
  always @(negedge clk) begin
    if (resetn && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_retire got=%0h exp=none", a_out_data);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_out_data", {32'd0, a_out_data}, e.data);
        chk("a_out_exc", {62'd0, a_out_exc}, {62'd0, e.exc});
        chk("a_out_badvaddr", {32'd0, a_out_badvaddr}, {32'd0, e.bad});
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_retire got=%0h exp=none", b_out_data);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_out_data", b_out_data, e.data);
        chk("b_out_exc", {62'd0, b_out_exc}, {62'd0, e.exc});
        chk("b_out_badvaddr", {32'd0, b_out_badvaddr}, {32'd0, e.bad});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_exp(input logic [31:0] data, input logic [1:0] exc, input logic [31:0] bad);
    qa.push_back('{data: {32'd0, data}, exc: exc, bad: bad});
  endtask

  task automatic b_exp(input logic [63:0] data);
    qb.push_back('{data: data, exc: 2'b00, bad: 32'd0});
  endtask

  task automatic a_drive(input logic [1:0] ls, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] data, input logic aok);
    a_in_valid  = 1'b1;
    a_in_ls     = ls;
    a_in_size   = size;
    a_in_sign   = sign;
    a_in_addr   = addr;
    a_in_data   = data;
    a_d_addr_ok = aok;
    #1;
  endtask

  task automatic b_drive(input logic [1:0] ls, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [63:0] data, input logic aok);
    b_in_valid  = 1'b1;
    b_in_ls     = ls;
    b_in_size   = size;
    b_in_sign   = sign;
    b_in_addr   = addr;
    b_in_data   = data;
    b_d_addr_ok = aok;
    #1;
  endtask

  task automatic a_idle;
    a_in_valid  = 1'b0;
    a_in_ls     = 2'b00;
    a_d_addr_ok = 1'b0;
  endtask

  task automatic b_idle;
    b_in_valid  = 1'b0;
    b_in_ls     = 2'b00;
    b_d_addr_ok = 1'b0;
  endtask

  // Single response from the cache for instance a, then one cycle to let it retire.
  task automatic a_respond(input logic [31:0] rdata);
    a_d_data_ok = 1'b1;
    a_d_rdata   = rdata;
    tick();
    a_d_data_ok = 1'b0;
    #1;
  endtask

  task automatic b_respond(input logic [63:0] rdata);
    b_d_data_ok = 1'b1;
    b_d_rdata   = rdata;
    tick();
    b_d_data_ok = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    a_in_valid = 0; a_in_ls = 0; a_in_size = 0; a_in_sign = 0; a_in_addr = 0; a_in_data = 0;
    a_d_addr_ok = 0; a_d_data_ok = 0; a_d_rdata = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_ls = 0; b_in_size = 0; b_in_sign = 0; b_in_addr = 0; b_in_data = 0;
    b_d_addr_ok = 0; b_d_data_ok = 0; b_d_rdata = 0; b_out_ready = 1;

    // Reset state.
    tick();
    tick();
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_d_req", {63'd0, a_d_req}, 64'd0);
    chk("rst_in_ready_idle", {63'd0, a_in_ready}, 64'd0);
    chk("rst_out_data", {32'd0, a_out_data}, 64'd0);
    chk("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    a_drive(2'b00, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_in_ready_nonmem", {63'd0, a_in_ready}, 64'd1);
    a_idle();
    tick();
    resetn = 1'b1;
    tick();

    // LB signed from 0x1003, response two cycles after addr_ok.
    a_drive(2'b01, 2'd0, 1'b1, 32'h1003, 32'h0, 1'b1);
    chk("lb_d_req", {63'd0, a_d_req}, 64'd1);
    chk("lb_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("lb_wstrb", {60'd0, a_d_wstrb}, 64'd0);
    chk("lb_d_size", {61'd0, a_d_size}, 64'd0);
    a_exp(32'hFFFF_FF80, 2'b00, 32'h0);
    tick();
    a_idle();
    tick();
    a_d_data_ok = 1'b1;
    a_d_rdata   = 32'h80AA_BBCC;
    #1;
    chk("lb_no_bypass", {63'd0, a_out_valid}, 64'd0);
    tick();
    a_d_data_ok = 1'b0;
    #1;
    chk("lb_valid_next", {63'd0, a_out_valid}, 64'd1);
    tick();

    // Non-memory pass-through, including the 11 encoding.
    a_drive(2'b00, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk("nm_in_ready", {63'd0, a_in_ready}, 64'd1);
    chk("nm_d_req", {63'd0, a_d_req}, 64'd0);
    a_exp(32'hDEAD_BEEF, 2'b00, 32'h0);
    tick();
    a_drive(2'b11, 2'd2, 1'b0, 32'h0, 32'h0000_0005, 1'b0);
    chk("nm11_d_req", {63'd0, a_d_req}, 64'd0);
    a_exp(32'h0000_0005, 2'b00, 32'h0);
    tick();
    a_idle();
    #1;
    chk("nm11_valid", {63'd0, a_out_valid}, 64'd1);
    tick();
    tick();

    // Misaligned accesses.
    a_drive(2'b01, 2'd2, 1'b0, 32'h1002, 32'h0, 1'b1);
    chk("lw_mis_d_req", {63'd0, a_d_req}, 64'd0);
    chk("lw_mis_in_ready", {63'd0, a_in_ready}, 64'd1);
    a_exp(32'h0, 2'b01, 32'h1002);
    tick();
    a_idle();
    #1;
    chk("lw_mis_valid", {63'd0, a_out_valid}, 64'd1);
    tick();
    a_drive(2'b10, 2'd2, 1'b0, 32'h1001, 32'hFFFF, 1'b1);
    chk("sw_mis_d_req", {63'd0, a_d_req}, 64'd0);
    a_exp(32'h0, 2'b10, 32'h1001);
    tick();
    a_idle();
    tick();
    a_drive(2'b10, 2'd3, 1'b0, 32'h2000, 32'h1, 1'b1);
    chk("sd32_d_req", {63'd0, a_d_req}, 64'd0);
    a_exp(32'h0, 2'b10, 32'h2000);
    tick();
    a_idle();
    tick();

    // Aligned SB lane steering.
    a_drive(2'b10, 2'd0, 1'b0, 32'h2002, 32'h0000_00AB, 1'b1);
    chk("sb_d_req", {63'd0, a_d_req}, 64'd1);
    chk("sb_d_wr", {63'd0, a_d_wr}, 64'd1);
    chk("sb_wstrb", {60'd0, a_d_wstrb}, 64'h4);
    chk("sb_wdata", {32'd0, a_d_wdata}, 64'h00AB_0000);
    a_exp(32'h0, 2'b00, 32'h0);
    tick();
    a_idle();
    a_respond(32'hFFFF_FFFF);
    chk("sb_valid", {63'd0, a_out_valid}, 64'd1);
    tick();

    // Full queue: two loads, third op stalls until the first retires; out_ready low 3 cycles.
    a_drive(2'b01, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1);
    a_exp(32'h11, 2'b00, 32'h0);
    tick();
    a_drive(2'b01, 2'd2, 1'b0, 32'h104, 32'h0, 1'b1);
    chk("full_second_ready", {63'd0, a_in_ready}, 64'd1);
    a_exp(32'h22, 2'b00, 32'h0);
    tick();
    a_out_ready = 1'b0;
    a_d_data_ok = 1'b1;
    a_d_rdata   = 32'h11;
    a_drive(2'b00, 2'd0, 1'b0, 32'h0, 32'h33, 1'b0);
    chk("full_stall_c", {63'd0, a_in_ready}, 64'd0);
    tick();
    a_d_rdata = 32'h22;
    #1;
    chk("full_stall_d", {63'd0, a_in_ready}, 64'd0);
    chk("full_hold_valid", {63'd0, a_out_valid}, 64'd1);
    tick();
    a_d_data_ok = 1'b0;
    #1;
    chk("full_stall_e", {63'd0, a_in_ready}, 64'd0);
    tick();
    a_out_ready = 1'b1;
    #1;
    chk("full_no_same_cycle", {63'd0, a_in_ready}, 64'd0);
    tick();
    chk("full_accept_after", {63'd0, a_in_ready}, 64'd1);
    a_exp(32'h33, 2'b00, 32'h0);
    tick();
    a_idle();
    tick();
    tick();

    // Flush with two loads in flight; the first two responses are stale.
    a_drive(2'b01, 2'd2, 1'b0, 32'h200, 32'h0, 1'b1);
    tick();
    a_drive(2'b01, 2'd2, 1'b0, 32'h204, 32'h0, 1'b1);
    tick();
    flush = 1'b1;
    a_drive(2'b01, 2'd2, 1'b0, 32'h208, 32'h0, 1'b1);
    chk("flush_d_req", {63'd0, a_d_req}, 64'd0);
    chk("flush_in_ready", {63'd0, a_in_ready}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("flush_reissue", {63'd0, a_d_req}, 64'd1);
    a_exp(32'h3333_3333, 2'b00, 32'h0);
    tick();
    a_idle();
    a_d_data_ok = 1'b1;
    a_d_rdata   = 32'h0000_BAD1;
    tick();
    a_d_rdata = 32'h0000_BAD2;
    #1;
    chk("discard1", {63'd0, a_out_valid}, 64'd0);
    tick();
    a_d_rdata = 32'h3333_3333;
    #1;
    chk("discard2", {63'd0, a_out_valid}, 64'd0);
    tick();
    a_d_data_ok = 1'b0;
    #1;
    chk("post_discard_valid", {63'd0, a_out_valid}, 64'd1);
    tick();

    // 64-bit instance.
    b_drive(2'b10, 2'd1, 1'b0, 32'h0000_1006, 64'h1234, 1'b1);
    chk("b_sh_d_req", {63'd0, b_d_req}, 64'd1);
    chk("b_sh_wstrb", {56'd0, b_d_wstrb}, 64'hC0);
    chk("b_sh_wdata", b_d_wdata, 64'h1234_0000_0000_0000);
    b_exp(64'h0);
    tick();
    b_idle();
    tick();
    b_respond(64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_sh_valid", {63'd0, b_out_valid}, 64'd1);
    tick();
    b_drive(2'b01, 2'd2, 1'b1, 32'h2004, 64'h0, 1'b1);
    chk("b_lw_wstrb", {56'd0, b_d_wstrb}, 64'h0);
    b_exp(64'hFFFF_FFFF_8000_0000);
    tick();
    b_idle();
    b_respond(64'h8000_0000_0000_0000);
    tick();
    b_drive(2'b01, 2'd3, 1'b0, 32'h2000, 64'h0, 1'b1);
    chk("b_ld_d_req", {63'd0, b_d_req}, 64'd1);
    b_exp(64'h8877_6655_4433_2211);
    tick();
    b_idle();
    b_respond(64'h8877_6655_4433_2211);
    tick();
    b_drive(2'b01, 2'd1, 1'b0, 32'h2006, 64'h0, 1'b1);
    b_exp(64'h0000_0000_0000_BEEF);
    tick();
    b_idle();
    b_respond(64'hBEEF_0000_0000_0000);
    tick();

    // Reset while a result is held and a load is pending.
    a_out_ready = 1'b0;
    a_drive(2'b00, 2'd0, 1'b0, 32'h0, 32'h77, 1'b0);
    tick();
    a_drive(2'b01, 2'd2, 1'b0, 32'h300, 32'h0, 1'b1);
    tick();
    a_idle();
    #1;
    chk("pre_rst_valid", {63'd0, a_out_valid}, 64'd1);
    chk("pre_rst_data", {32'd0, a_out_data}, 64'h77);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, a_out_valid}, 64'd0);
    chk("mid_rst_data", {32'd0, a_out_data}, 64'd0);
    qa.delete();
    tick();
    tick();
    resetn = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_drive(2'b01, 2'd2, 1'b0, 32'h400, 32'h0, 1'b1);
    chk("post_rst_d_req", {63'd0, a_d_req}, 64'd1);
    a_exp(32'h44, 2'b00, 32'h0);
    tick();
    a_idle();
    tick();
    a_respond(32'h44);
    chk("post_rst_valid", {63'd0, a_out_valid}, 64'd1);
    tick();
    tick();

    chk("a_all_retired", 64'(qa.size()), 64'd0);
    chk("b_all_retired", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
